// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the IMEM boot loader: data width, IMEM geometry and FSM encodings.
package imem_boot_loader_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned IMEM_BYTES  = 1024;
  localparam int unsigned IMEM_ADDR_W = $clog2(IMEM_BYTES);

  // Wide enough for the largest legal release delay (15).
  localparam int unsigned HOLD_W = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StHold = 2'd2;
  localparam logic [1:0] StRun  = 2'd3;

  typedef logic [DATA_WIDTH-1:0] byte_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Programming stream, IMEM byte write port and core control bundle for the boot loader.
interface imem_boot_loader_if
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) ();

  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              s_valid;
  byte_t             s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  byte_t             mem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  // Host / programmer side.
  modport master (
    output load_start, load_len, s_valid, s_data,
    input  s_ready, mem_we, mem_waddr, mem_wdata, cpu_rst_n, busy, done, err
  );

  // Loader side.
  modport slave (
    input  load_start, load_len, s_valid, s_data,
    output s_ready, mem_we, mem_waddr, mem_wdata, cpu_rst_n, busy, done, err
  );

endinterface

// File: rtl/boot_timeout_ctr.sv
// Saturating idle-cycle counter with clear/enable; flags when the count has reached LIMIT.
module boot_timeout_ctr #(
  parameter int unsigned LIMIT = 4096,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic reached
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign reached = (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !reached) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into IMEM from address 0 and holds the core in reset
// until a complete image has landed and the release delay has elapsed.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = IMEM_BYTES,
  parameter int unsigned ADDR_W      = IMEM_ADDR_W,
  parameter int unsigned TIMEOUT     = 4096,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_boot_loader_if.slave bus
);

  localparam int unsigned       LenW     = ADDR_W + 1;
  localparam logic [LenW-1:0]   MaxLen   = LenW'(MEM_BYTES);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(RELEASE_DLY - 1);

  logic [1:0]        state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic start_ok;
  logic accept;
  logic last_byte;
  logic idle_clr;
  logic idle_en;
  logic idle_hit;

  assign start_ok  = bus.load_start && (bus.load_len != '0) && (bus.load_len <= MaxLen);
  assign accept    = bus.s_valid && (state_q == StLoad);
  assign last_byte = (cnt_q == len_q - LenW'(1));

  // Clearing outside LOAD means every new load starts with a fresh idle count.
  assign idle_clr = (state_q != StLoad) || accept;
  assign idle_en  = (state_q == StLoad) && !accept;

  boot_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (idle_clr),
    .en      (idle_en),
    .reached (idle_hit)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle, StRun: begin
        if (bus.load_start) begin
          if (start_ok) begin
            state_d = StLoad;
            len_d   = bus.load_len;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // An accept in the same cycle as the timeout wins.
        if (accept) begin
          cnt_d = cnt_q + LenW'(1);
          if (last_byte) begin
            state_d = StHold;
            hold_d  = '0;
          end
        end else if (idle_hit) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_ready   = (state_q == StLoad);
  assign bus.mem_we    = accept;
  assign bus.mem_waddr = accept ? cnt_q[ADDR_W-1:0] : '0;
  assign bus.mem_wdata = accept ? bus.s_data : '0;
  assign bus.cpu_rst_n = (state_q == StRun);
  assign bus.busy      = (state_q == StLoad) || (state_q == StHold);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: scoreboarded IMEM writes plus release, error and reset checks.
module tb_imem_boot_loader;

  localparam int unsigned MEM_BYTES   = 1024;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned TIMEOUT     = 4096;
  localparam int unsigned RELEASE_DLY = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic clk;
  logic rst_n;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(
    .MEM_BYTES   (MEM_BYTES),
    .ADDR_W      (ADDR_W),
    .TIMEOUT     (TIMEOUT),
    .RELEASE_DLY (RELEASE_DLY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         exp_q[$];
  logic [7:0]  img [MEM_BYTES];
  int          we_cnt   = 0;
  int          err_cnt  = 0;
  int          done_cnt = 0;
  int          last_addr = -1;
  logic [7:0]  prog [8] = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h70, 8'h00};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe the current cycle's outputs; writes are matched against the scoreboard.
  task automatic sample();
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(bus.mem_waddr), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(bus.mem_waddr), 64'(e.addr));
        check("write_data", 64'(bus.mem_wdata), 64'(e.data));
      end
      img[bus.mem_waddr] = bus.mem_wdata;
      last_addr = int'(bus.mem_waddr);
    end
    if (bus.err === 1'b1)  err_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic cyc(input logic st, input logic [ADDR_W:0] len, input logic v,
                     input logic [7:0] d);
    @(negedge clk);
    bus.load_start = st;
    bus.load_len   = len;
    bus.s_valid    = v;
    bus.s_data     = d;
    #1;
    sample();
  endtask

  task automatic send_byte(input int idx, input logic [7:0] d);
    wr_t e;
    e.addr = ADDR_W'(idx);
    e.data = d;
    exp_q.push_back(e);
    cyc(1'b0, '0, 1'b1, d);
  endtask

  task automatic wait_run(input int bound, output int n);
    n = 0;
    while (bus.cpu_rst_n !== 1'b1 && n < bound) begin
      cyc(1'b0, '0, 1'b0, 8'h00);
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.load_start = 1'b0;
    bus.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;
    int w0;
    int d0;

    for (int i = 0; i < int'(MEM_BYTES); i++) img[i] = 8'h00;
    rst_n = 1'b0;
    bus.load_start = 1'b0;
    bus.load_len = '0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h5A;
    #12;
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_waddr", 64'(bus.mem_waddr), 64'd0);
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_cpu_rst_n", 64'(bus.cpu_rst_n), 64'd0);
    check("rst_busy_done_err", 64'({bus.busy, bus.done, bus.err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal 8-byte load, back to back.
    cyc(1'b1, 11'd8, 1'b0, 8'h00);
    check("idle_s_ready", 64'(bus.s_ready), 64'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(i, prog[i]);
      check("load_s_ready", 64'(bus.s_ready), 64'd1);
    end
    for (int j = 1; j <= int'(RELEASE_DLY); j++) begin
      cyc(1'b0, '0, 1'b0, 8'h00);
      check("hold_cpu_rst_n", 64'({bus.cpu_rst_n, bus.busy, bus.s_ready}), 64'b010);
    end
    cyc(1'b0, '0, 1'b0, 8'h00);
    check("release_cpu_rst_n", 64'({bus.cpu_rst_n, bus.busy, bus.done}), 64'b101);
    cyc(1'b0, '0, 1'b0, 8'h00);
    check("done_single_pulse", 64'(done_cnt), 64'd1);
    check("nominal_writes", 64'(we_cnt), 64'd8);
    check("word0", 64'({img[3], img[2], img[1], img[0]}), 64'h0000_0093);
    check("word1", 64'({img[7], img[6], img[5], img[4]}), 64'h0070_0113);

    // Reload from RUN with random gaps on s_valid.
    e0 = err_cnt;
    w0 = we_cnt;
    cyc(1'b1, 11'd8, 1'b0, 8'h00);
    cyc(1'b0, '0, 1'b0, 8'h00);
    check("reload_cpu_rst_n_low", 64'({bus.cpu_rst_n, bus.busy}), 64'b01);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 6)) cyc(1'b0, '0, 1'b0, 8'hEE);
      send_byte(i, prog[i]);
    end
    wait_run(RELEASE_DLY + 3, n);
    check("gaps_reached_run", 64'(bus.cpu_rst_n), 64'd1);
    check("gaps_no_err", 64'(err_cnt - e0), 64'd0);
    check("gaps_writes", 64'(we_cnt - w0), 64'd8);
    check("gaps_word0", 64'({img[3], img[2], img[1], img[0]}), 64'h0000_0093);
    check("gaps_word1", 64'({img[7], img[6], img[5], img[4]}), 64'h0070_0113);

    // Invalid start while running: err only, core keeps running.
    cyc(1'b1, 11'd0, 1'b0, 8'h00);
    cyc(1'b0, '0, 1'b0, 8'h00);
    check("run_badlen_err", 64'({bus.err, bus.cpu_rst_n, bus.busy}), 64'b110);

    // Bad lengths from IDLE.
    do_reset();
    w0 = we_cnt;
    cyc(1'b1, 11'd0, 1'b1, 8'h11);
    cyc(1'b0, '0, 1'b1, 8'h22);
    check("len0_err", 64'({bus.err, bus.busy, bus.s_ready}), 64'b100);
    cyc(1'b1, 11'(MEM_BYTES + 1), 1'b1, 8'h33);
    cyc(1'b0, '0, 1'b1, 8'h44);
    check("len_over_err", 64'({bus.err, bus.busy, bus.s_ready}), 64'b100);
    cyc(1'b0, '0, 1'b0, 8'h00);
    check("badlen_err_once", 64'(bus.err), 64'd0);
    check("badlen_no_write", 64'(we_cnt - w0), 64'd0);

    // Timeout after 3 of 8 bytes.
    e0 = err_cnt;
    w0 = we_cnt;
    cyc(1'b1, 11'd8, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(i, 8'hA0 + 8'(i));
    n = 0;
    while (bus.err !== 1'b1 && n < int'(TIMEOUT) + 8) begin
      cyc(1'b0, '0, 1'b0, 8'h00);
      n++;
    end
    check("timeout_err_seen", 64'(bus.err), 64'd1);
    check("timeout_not_early", 64'(n >= int'(TIMEOUT)), 64'd1);
    check("timeout_not_late", 64'(n <= int'(TIMEOUT) + 2), 64'd1);
    check("timeout_idle", 64'({bus.busy, bus.cpu_rst_n, bus.s_ready}), 64'b000);
    cyc(1'b0, '0, 1'b1, 8'hFF);
    check("timeout_err_once", 64'(err_cnt - e0), 64'd1);
    check("timeout_writes", 64'(we_cnt - w0), 64'd3);
    check("timeout_tail_kept", 64'({img[4], img[3]}), 64'h1300);

    // Full memory load.
    w0 = we_cnt;
    d0 = done_cnt;
    cyc(1'b1, 11'(MEM_BYTES), 1'b0, 8'h00);
    for (int i = 0; i < int'(MEM_BYTES); i++) send_byte(i, 8'(i) ^ 8'h5A);
    wait_run(RELEASE_DLY + 3, n);
    check("full_reached_run", 64'(bus.cpu_rst_n), 64'd1);
    check("full_writes", 64'(we_cnt - w0), 64'(MEM_BYTES));
    check("full_last_addr", 64'(last_addr), 64'(MEM_BYTES - 1));
    check("full_last_data", 64'(img[MEM_BYTES-1]), 64'(8'hFF ^ 8'h5A));
    check("full_done", 64'(done_cnt - d0), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Reload, then async reset mid-LOAD.
    e0 = err_cnt;
    cyc(1'b1, 11'd8, 1'b0, 8'h00);
    cyc(1'b0, '0, 1'b0, 8'h00);
    check("reload2_cpu_rst_n_low", 64'(bus.cpu_rst_n), 64'd0);
    send_byte(0, 8'h77);
    send_byte(1, 8'h88);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    check("midrst_outputs",
          64'({bus.s_ready, bus.cpu_rst_n, bus.busy, bus.done, bus.err}), 64'd0);
    check("midrst_bus", 64'({bus.mem_waddr, bus.mem_wdata}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      sample();
    end
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0, 8'h00);
    check("midrst_no_err", 64'(err_cnt - e0), 64'd0);
    check("midrst_idle", 64'({bus.busy, bus.cpu_rst_n}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
